mem_copy_engine: RTL and testbench

Bus-initiating block-copy engine that drives the `data_memory` port set: `mem_read`, `mem_write`, `address`, `write_data`, and `read_data` in. On a start command it reads `length` consecutive 16-bit words from a source byte address and writes them in ascending order to a destination byte address, one word every two cycles. It sits beside the datapath as a second master of data memory; external muxing of the two masters is outside this block.

---
 rtl/mem_copy_engine_if.sv | 42 ++++
 rtl/mem_copy_engine.sv | 186 ++++++++++++++++++
 tb/tb_mem_copy_engine.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_copy_engine_if.sv
// -----------------------------------------------------------------------------
// mem_copy_engine_if
// Groups the copy engine's command handshake and its data-memory master port.
//   master modport : the copy engine itself
//                    in  : start, src_addr, dst_addr, length, read_data
//                    out : busy, done, error, words_done,
//                          mem_read, mem_write, address, write_data
//   slave modport  : the command issuer / memory side (directions mirrored)
// -----------------------------------------------------------------------------
interface mem_copy_engine_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16,
    parameter int LEN_WIDTH  = 7
) ();
    // command side
    logic                  start;
    logic [ADDR_WIDTH-1:0] src_addr;
    logic [ADDR_WIDTH-1:0] dst_addr;
    logic [LEN_WIDTH-1:0]  length;
    logic                  busy;
    logic                  done;
    logic                  error;
    logic [LEN_WIDTH-1:0]  words_done;
    // data-memory side
    logic                  mem_read;
    logic                  mem_write;
    logic [ADDR_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0] write_data;
    logic [DATA_WIDTH-1:0] read_data;

    modport master (
        input  start, src_addr, dst_addr, length, read_data,
        output busy, done, error, words_done,
               mem_read, mem_write, address, write_data
    );

    modport slave (
        output start, src_addr, dst_addr, length, read_data,
        input  busy, done, error, words_done,
               mem_read, mem_write, address, write_data
    );
endinterface

// File: rtl/mem_copy_engine.sv
// -----------------------------------------------------------------------------
// mem_copy_engine
// Block-copy engine acting as a second master on data memory. A start command
// copies `length` 16-bit words from an even source byte address to an even
// destination byte address in ascending order, one word every two cycles
// (READ cycle then WRITE cycle). Illegal commands (odd address or a range that
// runs past MEM_WORDS) are answered with done+error and no memory traffic.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous, active-high
//   bus   : mem_copy_engine_if.master (command handshake + memory port)
// All outputs are driven straight from registers.
// -----------------------------------------------------------------------------
module mem_copy_engine #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16,
    parameter int LEN_WIDTH  = 7,
    parameter int MEM_WORDS  = 64
) (
    input  logic clk,
    input  logic reset,
    mem_copy_engine_if.master bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic [ADDR_WIDTH:0]   MEM_WORDS_C = (ADDR_WIDTH+1)'(MEM_WORDS);
    localparam logic [ADDR_WIDTH-1:0] ADDR_STEP_C = {{(ADDR_WIDTH-2){1'b0}}, 2'b10};
    localparam logic [LEN_WIDTH-1:0]  LEN_ONE_C   = {{(LEN_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [LEN_WIDTH-1:0]  LEN_ZERO_C  = {LEN_WIDTH{1'b0}};

    state_e                 state_r, state_nxt_s;

    logic [ADDR_WIDTH-1:0]  src_ptr_r, src_ptr_nxt_s;
    logic [ADDR_WIDTH-1:0]  dst_ptr_r, dst_ptr_nxt_s;
    logic [LEN_WIDTH-1:0]   len_r, len_nxt_s;
    logic [LEN_WIDTH-1:0]   words_done_r, words_done_nxt_s, words_inc_s;

    logic [ADDR_WIDTH:0]    src_end_s, dst_end_s;
    logic                   reject_s;

    logic                   busy_r, busy_nxt_s;
    logic                   done_r, done_nxt_s;
    logic                   error_r, error_nxt_s;
    logic                   mem_read_r, mem_read_nxt_s;
    logic                   mem_write_r, mem_write_nxt_s;
    logic [ADDR_WIDTH-1:0]  address_r, address_nxt_s;
    logic [DATA_WIDTH-1:0]  write_data_r, write_data_nxt_s;

    // Command legality: word-index end points computed one bit wider so they cannot wrap.
    always_comb begin
        src_end_s = {2'b00, bus.src_addr[ADDR_WIDTH-1:1]}
                  + {{(ADDR_WIDTH+1-LEN_WIDTH){1'b0}}, bus.length};
        dst_end_s = {2'b00, bus.dst_addr[ADDR_WIDTH-1:1]}
                  + {{(ADDR_WIDTH+1-LEN_WIDTH){1'b0}}, bus.length};
        reject_s  = bus.src_addr[0] | bus.dst_addr[0]
                  | (src_end_s > MEM_WORDS_C) | (dst_end_s > MEM_WORDS_C);
        words_inc_s = words_done_r + LEN_ONE_C;
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    if (reject_s || (bus.length == LEN_ZERO_C)) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_READ;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_READ:  state_nxt_s = ST_WRITE;
            ST_WRITE: begin
                // words_inc_s is the count after this write completes
                if (words_inc_s == len_r) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_READ;
                end
            end
            ST_DONE:  state_nxt_s = ST_IDLE;
            default:  state_nxt_s = ST_IDLE;
        endcase
    end

    // Datapath and next output values; outputs are registered from these so they
    // line up with the state they describe.
    always_comb begin
        src_ptr_nxt_s    = src_ptr_r;
        dst_ptr_nxt_s    = dst_ptr_r;
        len_nxt_s        = len_r;
        words_done_nxt_s = words_done_r;
        write_data_nxt_s = write_data_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    src_ptr_nxt_s    = bus.src_addr;
                    dst_ptr_nxt_s    = bus.dst_addr;
                    len_nxt_s        = bus.length;
                    words_done_nxt_s = LEN_ZERO_C;
                end else begin
                    src_ptr_nxt_s    = src_ptr_r;
                end
            end
            ST_READ: begin
                // write_data register doubles as the word buffer
                write_data_nxt_s = bus.read_data;
            end
            ST_WRITE: begin
                src_ptr_nxt_s    = src_ptr_r + ADDR_STEP_C;
                dst_ptr_nxt_s    = dst_ptr_r + ADDR_STEP_C;
                words_done_nxt_s = words_inc_s;
            end
            ST_DONE:  src_ptr_nxt_s = src_ptr_r;
            default:  src_ptr_nxt_s = src_ptr_r;
        endcase

        busy_nxt_s      = (state_nxt_s == ST_READ) || (state_nxt_s == ST_WRITE);
        mem_read_nxt_s  = (state_nxt_s == ST_READ);
        mem_write_nxt_s = (state_nxt_s == ST_WRITE);
        done_nxt_s      = (state_nxt_s == ST_DONE);
        error_nxt_s     = (state_r == ST_IDLE) && bus.start && reject_s;
        case (state_nxt_s)
            ST_READ:  address_nxt_s = src_ptr_nxt_s;
            ST_WRITE: address_nxt_s = dst_ptr_nxt_s;
            default:  address_nxt_s = {ADDR_WIDTH{1'b0}};
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            src_ptr_r    <= {ADDR_WIDTH{1'b0}};
            dst_ptr_r    <= {ADDR_WIDTH{1'b0}};
            len_r        <= LEN_ZERO_C;
            words_done_r <= LEN_ZERO_C;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            error_r      <= 1'b0;
            mem_read_r   <= 1'b0;
            mem_write_r  <= 1'b0;
            address_r    <= {ADDR_WIDTH{1'b0}};
            write_data_r <= {DATA_WIDTH{1'b0}};
        end else begin
            src_ptr_r    <= src_ptr_nxt_s;
            dst_ptr_r    <= dst_ptr_nxt_s;
            len_r        <= len_nxt_s;
            words_done_r <= words_done_nxt_s;
            busy_r       <= busy_nxt_s;
            done_r       <= done_nxt_s;
            error_r      <= error_nxt_s;
            mem_read_r   <= mem_read_nxt_s;
            mem_write_r  <= mem_write_nxt_s;
            address_r    <= address_nxt_s;
            write_data_r <= write_data_nxt_s;
        end
    end

    assign bus.busy       = busy_r;
    assign bus.done       = done_r;
    assign bus.error      = error_r;
    assign bus.words_done = words_done_r;
    assign bus.mem_read   = mem_read_r;
    assign bus.mem_write  = mem_write_r;
    assign bus.address    = address_r;
    assign bus.write_data = write_data_r;

endmodule

// File: tb/tb_mem_copy_engine.sv
// -----------------------------------------------------------------------------
// tb_mem_copy_engine
// Directed + randomized bench for mem_copy_engine. A 64-word memory sits on the
// engine's bus; a reference array models the memory contents as an ascending
// word-by-word copy, and a per-cycle schedule (READ at 1+2k, WRITE at 2+2k,
// DONE at 1+2L) is checked for every command.
// -----------------------------------------------------------------------------
module tb_mem_copy_engine;

    logic clk;
    logic reset;
    logic init_req;

    int n_tests;
    int n_fail;

    logic [15:0] mem     [0:63];
    logic [15:0] ref_mem [0:63];

    mem_copy_engine_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .LEN_WIDTH(7)) bus ();

    mem_copy_engine #(
        .ADDR_WIDTH(16), .DATA_WIDTH(16), .LEN_WIDTH(7), .MEM_WORDS(64)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Asynchronous-read memory model
    assign bus.read_data = mem[bus.address[6:1]];

    always @(posedge clk) begin
        if (init_req) begin
            for (int i = 0; i < 64; i++) mem[i] <= ref_mem[i];
        end else if (bus.mem_write) begin
            mem[bus.address[6:1]] <= bus.write_data;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run did not finish, observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic load_mem();
        @(negedge clk);
        init_req = 1'b1;
        @(negedge clk);
        init_req = 1'b0;
    endtask

    task automatic mem_check(input string tag);
        int bad;
        bad = 0;
        for (int i = 0; i < 64; i++) begin
            if (mem[i] !== ref_mem[i]) bad++;
        end
        chk({tag, " mem_words_wrong"}, 32'(bad), 32'd0);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, " busy"},       32'(bus.busy),       32'd0);
        chk({tag, " done"},       32'(bus.done),       32'd0);
        chk({tag, " error"},      32'(bus.error),      32'd0);
        chk({tag, " mem_read"},   32'(bus.mem_read),   32'd0);
        chk({tag, " mem_write"},  32'(bus.mem_write),  32'd0);
        chk({tag, " address"},    32'(bus.address),    32'd0);
    endtask

    // Issue one command and check every cycle through two cycles past done.
    // glitch_c >= 1 pulses start with junk operands in that cycle.
    task automatic run_cmd(input string tag, input logic [15:0] s, input logic [15:0] d,
                           input logic [6:0] n, input int glitch_c);
        logic [15:0] tmp    [0:63];
        logic [15:0] exp_wd [0:63];
        int  sw, dw, L, k, done_cnt;
        bit  rej;
        string t;
        sw  = int'(s >> 1);
        dw  = int'(d >> 1);
        rej = s[0] || d[0] || (sw + int'(n) > 64) || (dw + int'(n) > 64);
        L   = rej ? 0 : int'(n);
        tmp = ref_mem;
        for (int j = 0; j < L; j++) begin
            tmp[dw + j] = tmp[sw + j];
            exp_wd[j]   = tmp[dw + j];
        end
        done_cnt = 0;

        @(negedge clk);
        bus.start    = 1'b1;
        bus.src_addr = s;
        bus.dst_addr = d;
        bus.length   = n;
        @(posedge clk);
        for (int c = 1; c <= 2 * L + 3; c++) begin
            @(negedge clk);
            if (c == glitch_c) begin
                bus.start    = 1'b1;
                bus.src_addr = 16'($urandom_range(0, 31)) << 1;
                bus.dst_addr = 16'($urandom_range(0, 31)) << 1;
                bus.length   = 7'($urandom_range(1, 8));
            end else begin
                bus.start = 1'b0;
            end
            t = $sformatf("%s c%0d", tag, c);
            if (bus.done === 1'b1) done_cnt++;
            chk({t, " rd_wr_excl"}, 32'(bus.mem_read & bus.mem_write), 32'd0);
            if (c <= 2 * L) begin
                k = (c - 1) / 2;
                chk({t, " busy"},       32'(bus.busy),       32'd1);
                chk({t, " done"},       32'(bus.done),       32'd0);
                chk({t, " words_done"}, 32'(bus.words_done), 32'(k));
                if (c % 2 == 1) begin
                    chk({t, " mem_read"},  32'(bus.mem_read),  32'd1);
                    chk({t, " mem_write"}, 32'(bus.mem_write), 32'd0);
                    chk({t, " rd_addr"},   32'(bus.address),   32'(int'(s) + 2 * k));
                end else begin
                    chk({t, " mem_read"},  32'(bus.mem_read),  32'd0);
                    chk({t, " mem_write"}, 32'(bus.mem_write), 32'd1);
                    chk({t, " wr_addr"},   32'(bus.address),   32'(int'(d) + 2 * k));
                    chk({t, " wr_data"},   32'(bus.write_data), 32'(exp_wd[k]));
                end
            end else if (c == 2 * L + 1) begin
                chk({t, " done"},       32'(bus.done),       32'd1);
                chk({t, " error"},      32'(bus.error),      32'(rej));
                chk({t, " busy"},       32'(bus.busy),       32'd0);
                chk({t, " mem_read"},   32'(bus.mem_read),   32'd0);
                chk({t, " mem_write"},  32'(bus.mem_write),  32'd0);
                chk({t, " address"},    32'(bus.address),    32'd0);
                chk({t, " words_done"}, 32'(bus.words_done), 32'(L));
            end else begin
                check_idle_outputs(t);
                chk({t, " words_done"}, 32'(bus.words_done), 32'(L));
            end
        end
        bus.start = 1'b0;
        chk({tag, " done_pulses"}, 32'(done_cnt), 32'd1);
        ref_mem = tmp;
        mem_check(tag);
    endtask

    initial begin
        int n, sw, dw;
        n_tests      = 0;
        n_fail       = 0;
        init_req     = 1'b0;
        reset        = 1'b0;
        bus.start    = 1'b0;
        bus.src_addr = 16'h0000;
        bus.dst_addr = 16'h0000;
        bus.length   = 7'd0;

        // Reset asserted mid-cycle: outputs clear before any clock edge
        #2 reset = 1'b1;
        #1;
        check_idle_outputs("reset");
        chk("reset write_data", 32'(bus.write_data), 32'd0);
        chk("reset words_done", 32'(bus.words_done), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 64; i++) ref_mem[i] = 16'($urandom);
        ref_mem[0] = 16'd5;
        ref_mem[1] = 16'd7;
        load_mem();

        // Basic copy
        run_cmd("basic", 16'h0000, 16'h0020, 7'd2, 0);
        chk("basic mem16", 32'(mem[16]), 32'd5);
        chk("basic mem17", 32'(mem[17]), 32'd7);

        // Zero length
        run_cmd("zero_len", 16'h0004, 16'h0008, 7'd0, 0);

        // Rejections
        run_cmd("rej_odd_src", 16'h0003, 16'h0020, 7'd1, 0);
        run_cmd("rej_range",   16'h007C, 16'h0000, 7'd3, 0);
        run_cmd("rej_odd_dst", 16'h0000, 16'h0021, 7'd2, 0);
        run_cmd("rej_dst_rng", 16'h0000, 16'h0070, 7'd9, 0);
        run_cmd("edge_fit",    16'h0078, 16'h0000, 7'd4, 0);

        // Busy guard: start pulsed during the first WRITE cycle
        run_cmd("busy_guard", 16'h0010, 16'h0040, 7'd4, 2);

        // Randomized commands, some with ascending overlap
        for (int r = 0; r < 10; r++) begin
            n = $urandom_range(1, 8);
            if (r % 3 == 0) begin
                sw = $urandom_range(0, 63 - n);
                dw = sw + 1;
            end else begin
                sw = $urandom_range(0, 64 - n);
                dw = $urandom_range(0, 64 - n);
            end
            run_cmd($sformatf("rand%0d", r), 16'(sw * 2), 16'(dw * 2), 7'(n), 0);
        end
        run_cmd("rand_rej", 16'(($urandom_range(57, 63)) * 2), 16'h0000, 7'd8, 0);

        // Abort: reset during WRITE of word 1 of a 4-word copy
        @(negedge clk);
        bus.start    = 1'b1;
        bus.src_addr = 16'h0000;
        bus.dst_addr = 16'h0050;
        bus.length   = 7'd4;
        @(posedge clk);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        chk("abort pre mem_write", 32'(bus.mem_write), 32'd1);
        #2 reset = 1'b1;
        #1;
        check_idle_outputs("abort");
        chk("abort write_data", 32'(bus.write_data), 32'd0);
        chk("abort words_done", 32'(bus.words_done), 32'd0);
        ref_mem[40] = ref_mem[0];
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        mem_check("abort");

        // Fresh command after the abort
        run_cmd("after_abort", 16'h0006, 16'h0060, 7'd1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
